shield_pwr_ctrl: RTL and testbench
==================================

SHIELD_PWR_CTRL -- requirements
Module: shield_pwr_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2, number of shield channels (1..8).
REQ-002 SHALL have parameter DEB_W, default 8, width of the OC debounce counter and threshold.
REQ-003 SHALL have parameter DEB_RST, default 16, reset value of the debounce threshold.
REQ-004 csi_MCLK_clk  in  1  sole clock; all state on its rising edge.
REQ-005 rsi_MRST_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 avs_ctrl_address  in  2  word address: 0 CTRL, 1 STATUS, 2 IRQ_EN, 3 DEBOUNCE.
REQ-007 avs_ctrl_writedata  in  32 / avs_ctrl_byteenable  in  4 / avs_ctrl_write  in  1 / avs_ctrl_read  in  1  Avalon-MM slave inputs.
REQ-008 avs_ctrl_readdata  out  32  read data; avs_ctrl_waitrequest  out  1  tied 0.
REQ-009 ins_OC_irq  out  1  level interrupt, registered.
REQ-010 coe_OCN  in  NCH  per-channel over-current flag, active-low, asynchronous to clk.
REQ-011 coe_PWREN_n  out  NCH  per-channel power switch, 1 = off; coe_HOE / coe_LOE  out  NCH  high/low buffer enables.

Function
REQ-012 CTRL bits: [i] PWR on, [8+i] HOE, [16+i] LOE, [24+i] AUTO_OFF; byte lane k writes only byte k; bits for i>=NCH read 0.
REQ-013 STATUS bits: [i] OC debounced (read-only), [8+i] OC sticky (write-1-to-clear, lane 1), [16+i] TRIPPED (read-only).
REQ-014 IRQ_EN bits [i] read/write; DEBOUNCE bits [DEB_W-1:0] read/write threshold T; T=0 behaves as T=1.
REQ-015 Reads SHALL be combinational from current register state, zero wait states; unused bits read 0.
REQ-016 Each coe_OCN[i] SHALL pass a 2-flop synchroniser; oc_sync[i]=1 means over-current present.
REQ-017 Per channel, counter cnt SHALL clear when oc_sync=0, else increment saturating at T; oc_deb=1 when cnt==T, 0 when oc_sync=0.
REQ-018 Latency pin assertion -> oc_deb SHALL be 2+T cycles; deassertion -> oc_deb clear SHALL be 3 cycles.
REQ-019 On oc_deb rising edge, sticky[i] SHALL set; if same-cycle W1C to that bit, set wins.
REQ-020 On oc_deb rising edge with AUTO_OFF[i]=1, PWR[i] SHALL clear and TRIPPED[i] SHALL set in the same cycle, overriding any same-cycle CTRL write.
REQ-021 CTRL write of PWR[i]=1 SHALL clear TRIPPED[i]; ignored (PWR stays 0, TRIPPED stays 1) while oc_deb[i]=1 and AUTO_OFF[i]=1.
REQ-022 coe_PWREN_n = ~PWR, coe_HOE = HOE, coe_LOE = LOE, all direct from registers.
REQ-023 ins_OC_irq SHALL be registered |(sticky & IRQ_EN), one cycle after the causing change.
REQ-024 Lowering T while a counter exceeds it SHALL assert oc_deb the next cycle (cnt >= T compare, cnt clamped).

Reset
REQ-025 On reset: PWR=0 (coe_PWREN_n all 1), HOE=0, LOE=0, AUTO_OFF=0, IRQ_EN=0, sticky=0, TRIPPED=0, cnt=0, synchronisers 0, T=DEB_RST, ins_OC_irq=0.
REQ-026 Reset asserted mid-trip SHALL return all channels to reset state immediately; no fault history retained.

Structure
REQ-027 Shared package SHALL hold register address constants, bit-offset constants (PWR 0, HOE 8, LOE 16, AUTO 24, STICKY 8, TRIP 16) and NCH upper bound 8.
REQ-028 Per-channel synchroniser+debouncer SHALL be a sub-module shield_oc_debounce, instantiated NCH times via generate.

Verification
REQ-029 Reset, read CTRL/STATUS/DEBOUNCE -> 0x0, 0x0, 0x10; coe_PWREN_n = all 1.
REQ-030 Write CTRL 0x0300_0303, hold coe_OCN[0]=0 for 20 cycles -> oc_deb at cycle 18, STATUS 0x0001_0101, coe_PWREN_n[0]=1, ch1 stays on.
REQ-031 OCN[1] low 10 cycles with T=16 -> no sticky, no irq; OCN[1] low 17 cycles -> sticky[1]=1.
REQ-032 IRQ_EN=0x1, trip ch0 -> irq 1 cycle after sticky; write STATUS 0x100 after OCN released -> irq drops next cycle.
REQ-033 While ch0 tripped and OCN[0] still low, write PWR[0]=1 -> ignored; after release, same write -> PWR on, TRIPPED clear.
REQ-034 W1C sticky[0] in the exact cycle oc_deb[0] rises -> sticky remains 1; reset pulse mid-trip -> all registers at reset values.

Source files
------------

// File: rtl/shield_pwr_ctrl_pkg.sv
// Shared definitions for the shield power controller.
// Holds the Avalon register map, the bit offset of each per-channel
// field inside its 32-bit register, and the largest supported channel
// count. Each field is one byte wide, so channel i sits at offset + i.
package shield_pwr_ctrl_pkg;

  // Largest supported number of shield channels (one byte lane per field)
  localparam int NCH_MAX = 8;

  // Word addresses on the control slave
  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN   = 2'd2;
  localparam logic [1:0] ADDR_DEBOUNCE = 2'd3;

  // CTRL field offsets
  localparam int OFS_PWR  = 0;
  localparam int OFS_HOE  = 8;
  localparam int OFS_LOE  = 16;
  localparam int OFS_AUTO = 24;

  // STATUS field offsets
  localparam int OFS_DEB    = 0;
  localparam int OFS_STICKY = 8;
  localparam int OFS_TRIP   = 16;

endpackage

// File: rtl/shield_oc_debounce.sv
// Per-channel over-current synchroniser and debouncer.
// The active-low OC flag is brought into the clock domain through two
// flops, then a saturating counter requires it to stay present for
// thresh consecutive cycles before oc_deb is raised. oc_deb is
// registered, so assertion takes 2+thresh cycles and release 3 cycles.
// Ports:
//   csi_MCLK_clk      clock
//   rsi_MRST_reset_n  asynchronous active-low reset
//   ocn               raw over-current flag, active-low, asynchronous
//   thresh            debounce threshold, must be nonzero
//   oc_deb            debounced over-current, 1 = present
module shield_oc_debounce #(
  parameter int DEB_W = 8
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset_n,
  input  logic             ocn,
  input  logic [DEB_W-1:0] thresh,
  output logic             oc_deb
);

  localparam logic [DEB_W-1:0] CNT_ONE = {{(DEB_W-1){1'b0}}, 1'b1};

  logic             sync1_reg;
  logic             sync2_reg;
  logic [DEB_W-1:0] cnt_reg;
  logic [DEB_W-1:0] cnt_next;
  logic             deb_reg;

  // The >= compare clamps the counter down immediately when the
  // threshold is lowered below the current count.
  always_comb begin
    cnt_next = '0;
    if (sync2_reg) begin
      cnt_next = (cnt_reg >= thresh) ? thresh : cnt_reg + CNT_ONE;
    end
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      deb_reg   <= 1'b0;
    end else begin
      sync1_reg <= ~ocn;
      sync2_reg <= sync1_reg;
      cnt_reg   <= cnt_next;
      deb_reg   <= sync2_reg && (cnt_next >= thresh);
    end
  end

  assign oc_deb = deb_reg;

endmodule

// File: rtl/shield_pwr_ctrl.sv
// Shield power controller: Avalon-MM register block driving per-channel
// power switches and buffer enables, with debounced over-current
// detection, sticky fault flags, optional automatic power-off and a
// level interrupt.
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset_n  clock, asynchronous active-low reset
//   avs_ctrl_*                      Avalon-MM slave (zero wait states)
//   ins_OC_irq                      registered level interrupt
//   coe_OCN                         per-channel over-current, active-low
//   coe_PWREN_n                     per-channel power switch, 1 = off
//   coe_HOE, coe_LOE                per-channel high/low buffer enables
module shield_pwr_ctrl
  import shield_pwr_ctrl_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DEB_W   = 8,
  parameter int DEB_RST = 16
) (
  input  logic           csi_MCLK_clk,
  input  logic           rsi_MRST_reset_n,
  input  logic [1:0]     avs_ctrl_address,
  input  logic [31:0]    avs_ctrl_writedata,
  input  logic [3:0]     avs_ctrl_byteenable,
  input  logic           avs_ctrl_write,
  input  logic           avs_ctrl_read,
  output logic [31:0]    avs_ctrl_readdata,
  output logic           avs_ctrl_waitrequest,
  output logic           ins_OC_irq,
  input  logic [NCH-1:0] coe_OCN,
  output logic [NCH-1:0] coe_PWREN_n,
  output logic [NCH-1:0] coe_HOE,
  output logic [NCH-1:0] coe_LOE
);

  localparam logic [DEB_W-1:0] THRESH_ONE = {{(DEB_W-1){1'b0}}, 1'b1};

  logic [NCH-1:0]   pwr_reg,    pwr_next;
  logic [NCH-1:0]   hoe_reg,    hoe_next;
  logic [NCH-1:0]   loe_reg,    loe_next;
  logic [NCH-1:0]   auto_reg,   auto_next;
  logic [NCH-1:0]   irq_en_reg, irq_en_next;
  logic [NCH-1:0]   sticky_reg, sticky_next;
  logic [NCH-1:0]   trip_reg,   trip_next;
  logic [DEB_W-1:0] thresh_reg, thresh_next;
  logic [NCH-1:0]   deb_prev_reg;
  logic             irq_reg;

  logic [NCH-1:0]   oc_deb;
  logic [NCH-1:0]   deb_rise;
  logic [DEB_W-1:0] thresh_eff;
  logic             wr_ctrl, wr_status, wr_irq_en, wr_deb;
  logic [31:0]      rdata_mux;
  logic             unused_wdata;

  assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL);
  assign wr_status = avs_ctrl_write && (avs_ctrl_address == ADDR_STATUS);
  assign wr_irq_en = avs_ctrl_write && (avs_ctrl_address == ADDR_IRQ_EN);
  assign wr_deb    = avs_ctrl_write && (avs_ctrl_address == ADDR_DEBOUNCE);

  // A zero threshold would never let the counter reach a match state
  // that differs from idle, so it is treated as one.
  assign thresh_eff = (thresh_reg == '0) ? THRESH_ONE : thresh_reg;
  assign deb_rise   = oc_deb & ~deb_prev_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      shield_oc_debounce #(
        .DEB_W(DEB_W)
      ) u_deb (
        .csi_MCLK_clk    (csi_MCLK_clk),
        .rsi_MRST_reset_n(rsi_MRST_reset_n),
        .ocn             (coe_OCN[gi]),
        .thresh          (thresh_eff),
        .oc_deb          (oc_deb[gi])
      );
    end
  endgenerate

  // Register updates. Fault events are applied last so they take
  // priority over any same-cycle host write to the same bit.
  always_comb begin
    pwr_next    = pwr_reg;
    hoe_next    = hoe_reg;
    loe_next    = loe_reg;
    auto_next   = auto_reg;
    irq_en_next = irq_en_reg;
    sticky_next = sticky_reg;
    trip_next   = trip_reg;
    thresh_next = thresh_reg;
    for (int i = 0; i < NCH; i++) begin
      if (wr_ctrl && avs_ctrl_byteenable[0]) begin
        if (avs_ctrl_writedata[OFS_PWR+i]) begin
          // Re-enabling is refused while a fault that would trip the
          // channel again is still present.
          if (!(oc_deb[i] && auto_reg[i])) begin
            pwr_next[i]  = 1'b1;
            trip_next[i] = 1'b0;
          end
        end else begin
          pwr_next[i] = 1'b0;
        end
      end
      if (wr_ctrl && avs_ctrl_byteenable[1]) hoe_next[i]  = avs_ctrl_writedata[OFS_HOE+i];
      if (wr_ctrl && avs_ctrl_byteenable[2]) loe_next[i]  = avs_ctrl_writedata[OFS_LOE+i];
      if (wr_ctrl && avs_ctrl_byteenable[3]) auto_next[i] = avs_ctrl_writedata[OFS_AUTO+i];
      if (wr_status && avs_ctrl_byteenable[1] && avs_ctrl_writedata[OFS_STICKY+i]) begin
        sticky_next[i] = 1'b0;
      end
      if (wr_irq_en && avs_ctrl_byteenable[0]) irq_en_next[i] = avs_ctrl_writedata[i];
      if (deb_rise[i]) begin
        sticky_next[i] = 1'b1;
        if (auto_reg[i]) begin
          pwr_next[i]  = 1'b0;
          trip_next[i] = 1'b1;
        end
      end
    end
    for (int b = 0; b < DEB_W; b++) begin
      if (wr_deb && avs_ctrl_byteenable[b/8]) thresh_next[b] = avs_ctrl_writedata[b];
    end
  end

  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      pwr_reg      <= '0;
      hoe_reg      <= '0;
      loe_reg      <= '0;
      auto_reg     <= '0;
      irq_en_reg   <= '0;
      sticky_reg   <= '0;
      trip_reg     <= '0;
      thresh_reg   <= DEB_RST[DEB_W-1:0];
      deb_prev_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      pwr_reg      <= pwr_next;
      hoe_reg      <= hoe_next;
      loe_reg      <= loe_next;
      auto_reg     <= auto_next;
      irq_en_reg   <= irq_en_next;
      sticky_reg   <= sticky_next;
      trip_reg     <= trip_next;
      thresh_reg   <= thresh_next;
      deb_prev_reg <= oc_deb;
      irq_reg      <= |(sticky_reg & irq_en_reg);
    end
  end

  // Combinational read mux; readdata is held at zero outside reads.
  always_comb begin
    rdata_mux = '0;
    case (avs_ctrl_address)
      ADDR_CTRL: begin
        for (int i = 0; i < NCH; i++) begin
          rdata_mux[OFS_PWR+i]  = pwr_reg[i];
          rdata_mux[OFS_HOE+i]  = hoe_reg[i];
          rdata_mux[OFS_LOE+i]  = loe_reg[i];
          rdata_mux[OFS_AUTO+i] = auto_reg[i];
        end
      end
      ADDR_STATUS: begin
        for (int i = 0; i < NCH; i++) begin
          rdata_mux[OFS_DEB+i]    = oc_deb[i];
          rdata_mux[OFS_STICKY+i] = sticky_reg[i];
          rdata_mux[OFS_TRIP+i]   = trip_reg[i];
        end
      end
      ADDR_IRQ_EN: begin
        for (int i = 0; i < NCH; i++) rdata_mux[i] = irq_en_reg[i];
      end
      default: rdata_mux = 32'(thresh_reg);
    endcase
    if (!avs_ctrl_read) rdata_mux = '0;
  end

  assign avs_ctrl_readdata    = rdata_mux;
  assign avs_ctrl_waitrequest = 1'b0;
  assign ins_OC_irq           = irq_reg;
  assign coe_PWREN_n          = ~pwr_reg;
  assign coe_HOE              = hoe_reg;
  assign coe_LOE              = loe_reg;

  // Only some writedata bits map to storage.
  assign unused_wdata = ^avs_ctrl_writedata;

endmodule

// File: tb/tb_shield_pwr_ctrl.sv
`timescale 1ns/1ps
module tb_shield_pwr_ctrl;

  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1:0]     addr = '0;
  logic [31:0]    wdata = '0;
  logic [3:0]     be = '0;
  logic           wr = 1'b0;
  logic           rd = 1'b0;
  logic [31:0]    rdata;
  logic           waitreq;
  logic           irq;
  logic [NCH-1:0] ocn = '1;
  logic [NCH-1:0] pwren_n, hoe, loe;

  always #5 clk = ~clk;

  shield_pwr_ctrl #(.NCH(NCH), .DEB_W(8), .DEB_RST(16)) dut (
    .csi_MCLK_clk        (clk),
    .rsi_MRST_reset_n    (rst_n),
    .avs_ctrl_address    (addr),
    .avs_ctrl_writedata  (wdata),
    .avs_ctrl_byteenable (be),
    .avs_ctrl_write      (wr),
    .avs_ctrl_read       (rd),
    .avs_ctrl_readdata   (rdata),
    .avs_ctrl_waitrequest(waitreq),
    .ins_OC_irq          (irq),
    .coe_OCN             (ocn),
    .coe_PWREN_n         (pwren_n),
    .coe_HOE             (hoe),
    .coe_LOE             (loe)
  );

  typedef struct {
    bit             rd_valid;
    logic [1:0]     rd_addr;
    logic [31:0]    rd_data;
    logic           irq;
    logic [NCH-1:0] pwren_n;
    logic [NCH-1:0] hoe;
    logic [NCH-1:0] loe;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: register contents as the host sees them.
  bit [NCH-1:0] m_pwr, m_hoe, m_loe, m_auto, m_irqen, m_sticky, m_trip;
  bit [NCH-1:0] m_deb, m_deb_last;
  bit           m_irq;
  int           m_T;
  // Length of the current run of consecutive low samples of each pin,
  // as of the latest edge and the edge before it.
  int           run_now[NCH], run_prev[NCH];

  function automatic void model_reset();
    m_pwr = '0; m_hoe = '0; m_loe = '0; m_auto = '0; m_irqen = '0;
    m_sticky = '0; m_trip = '0; m_deb = '0; m_deb_last = '0;
    m_irq = 1'b0; m_T = 16;
    for (int i = 0; i < NCH; i++) begin
      run_now[i] = 0;
      run_prev[i] = 0;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {8'(m_auto), 8'(m_loe), 8'(m_hoe), 8'(m_pwr)};
      2'd1:    return {8'h00, 8'(m_trip), 8'(m_sticky), 8'(m_deb)};
      2'd2:    return 32'(m_irqen);
      default: return 32'(m_T);
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs present now.
  function automatic void model_edge();
    bit [NCH-1:0] rise, auto_old;
    int teff;
    bit irq_new;
    if (!rst_n) begin
      model_reset();
      return;
    end
    teff     = (m_T == 0) ? 1 : m_T;
    rise     = m_deb & ~m_deb_last;
    auto_old = m_auto;
    irq_new  = |(m_sticky & m_irqen);
    if (wr) begin
      case (addr)
        2'd0: for (int i = 0; i < NCH; i++) begin
          if (be[0]) begin
            if (wdata[i]) begin
              if (!(m_deb[i] && auto_old[i])) begin
                m_pwr[i] = 1'b1;
                m_trip[i] = 1'b0;
              end
            end else begin
              m_pwr[i] = 1'b0;
            end
          end
          if (be[1]) m_hoe[i]  = wdata[8+i];
          if (be[2]) m_loe[i]  = wdata[16+i];
          if (be[3]) m_auto[i] = wdata[24+i];
        end
        2'd1: for (int i = 0; i < NCH; i++) begin
          if (be[1] && wdata[8+i]) m_sticky[i] = 1'b0;
        end
        2'd2: if (be[0]) m_irqen = wdata[NCH-1:0];
        default: if (be[0]) m_T = int'(wdata[7:0]);
      endcase
    end
    for (int i = 0; i < NCH; i++) begin
      if (rise[i]) begin
        m_sticky[i] = 1'b1;
        if (auto_old[i]) begin
          m_pwr[i] = 1'b0;
          m_trip[i] = 1'b1;
        end
      end
    end
    m_irq = irq_new;
    // Over-current is reported once the pin has been seen low for T
    // consecutive samples, ending two samples ago (synchroniser delay).
    m_deb_last = m_deb;
    for (int i = 0; i < NCH; i++) begin
      m_deb[i]    = (run_prev[i] >= teff);
      run_prev[i] = run_now[i];
      run_now[i]  = (ocn[i] == 1'b0) ? run_now[i] + 1 : 0;
    end
  endfunction

  function automatic void push_expect();
    exp_t e;
    e.rd_valid = rd;
    e.rd_addr  = addr;
    e.rd_data  = model_read(addr);
    e.irq      = m_irq;
    e.pwren_n  = ~m_pwr;
    e.hoe      = m_hoe;
    e.loe      = m_loe;
    exp_q.push_back(e);
  endfunction

  // One bus cycle: entered and left 1 ns after a rising edge.
  task automatic drive(input logic [1:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic w, input logic r);
    addr = a; wdata = d; be = b; wr = w; rd = r;
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    drive(2'd0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic wr_op(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(a, d, b, 1'b1, 1'b0);
  endtask

  task automatic rd_op(input logic [1:0] a);
    drive(a, 32'h0, 4'h0, 1'b0, 1'b1);
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h t=%0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every cycle the DUT presents its outputs; compare them
  // against the oldest expectation queued by the stimulus side.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pwren_n", 32'(pwren_n), 32'(e.pwren_n));
        chk("hoe", 32'(hoe), 32'(e.hoe));
        chk("loe", 32'(loe), 32'(e.loe));
        chk("irq", 32'(irq), 32'(e.irq));
        chk("waitrequest", 32'(waitreq), 32'h0);
        if (e.rd_valid) begin
          chk($sformatf("read_addr%0d", e.rd_addr), rdata, e.rd_data);
          $display("read addr=%0d data=%08h expected=%08h t=%0t", e.rd_addr, rdata, e.rd_data, $time);
        end
      end
    end
  end

  initial begin : stimulus
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    idle();
    idle();
    rst_n = 1'b1;
    idle();

    // Reset values
    rd_op(2'd0);
    rd_op(2'd1);
    rd_op(2'd3);

    // Both channels on with HOE and auto-off; trip channel 0
    wr_op(2'd0, 32'h0300_0303, 4'hF);
    ocn[0] = 1'b0;
    repeat (20) idle();
    rd_op(2'd1);
    rd_op(2'd0);

    // Re-enable refused while the fault persists, accepted after release
    wr_op(2'd0, 32'h0300_0303, 4'hF);
    rd_op(2'd0);
    rd_op(2'd1);
    ocn[0] = 1'b1;
    repeat (4) idle();
    wr_op(2'd0, 32'h0300_0303, 4'hF);
    rd_op(2'd0);
    rd_op(2'd1);
    wr_op(2'd1, 32'h0000_0100, 4'h2);
    rd_op(2'd1);

    // Short glitch on channel 1 is filtered; a 17-cycle fault is not
    ocn[1] = 1'b0;
    repeat (10) idle();
    ocn[1] = 1'b1;
    repeat (4) idle();
    rd_op(2'd1);
    ocn[1] = 1'b0;
    repeat (17) idle();
    ocn[1] = 1'b1;
    repeat (4) idle();
    rd_op(2'd1);
    rd_op(2'd0);

    // Interrupt follows sticky & enable, and drops after clearing
    wr_op(2'd2, 32'h0000_0001, 4'h1);
    wr_op(2'd1, 32'h0000_FF00, 4'h2);
    wr_op(2'd0, 32'h0300_0303, 4'hF);
    ocn[0] = 1'b0;
    repeat (20) idle();
    ocn[0] = 1'b1;
    repeat (4) idle();
    rd_op(2'd1);
    wr_op(2'd1, 32'h0000_0100, 4'hF);
    repeat (3) idle();
    rd_op(2'd1);

    // Clear sticky in the very cycle oc_deb rises: the set must win
    wr_op(2'd0, 32'h0300_0303, 4'hF);
    ocn[0] = 1'b0;
    for (int k = 0; k < 40 && !(m_deb[0] && !m_deb_last[0]); k++) idle();
    wr_op(2'd1, 32'h0000_0100, 4'h2);
    rd_op(2'd1);
    idle();

    // Reset pulse in the middle of a trip
    rst_n = 1'b0;
    model_reset();
    rd_op(2'd0);
    rd_op(2'd1);
    rst_n = 1'b1;
    rd_op(2'd1);
    rd_op(2'd2);
    rd_op(2'd3);
    ocn = '1;
    repeat (4) idle();

    // Lowering the threshold below a running count asserts next cycle
    ocn[1] = 1'b0;
    repeat (10) idle();
    wr_op(2'd3, 32'h0000_0004, 4'h1);
    rd_op(2'd1);
    rd_op(2'd1);
    ocn[1] = 1'b1;
    repeat (4) idle();

    // Randomised traffic with a short threshold, then with T = 0
    wr_op(2'd3, 32'h0000_0002, 4'h1);
    for (int n = 0; n < 1600; n++) begin
      if (n == 800) begin
        ocn = '1;
        repeat (4) idle();
        wr_op(2'd3, 32'h0000_0000, 4'h1);
        rd_op(2'd3);
      end
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 15) == 0) ocn[c] = ~ocn[c];
      end
      case ($urandom_range(0, 7))
        0:       wr_op(2'd0, $urandom, 4'($urandom));
        1:       wr_op(2'd1, $urandom, 4'($urandom));
        2:       wr_op(2'd2, $urandom, 4'($urandom));
        3, 4:    rd_op(2'($urandom_range(0, 3)));
        default: idle();
      endcase
    end
    ocn = '1;
    repeat (4) idle();
    rd_op(2'd1);
    idle();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
